// File: rtl/aurora_mem_pkg.sv
// Types and widths shared by the EX/MEM register, the memory stage and MEM/WB.
// FSM state encoding for the data-memory bus controller lives here.
package aurora_mem_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus with req/gnt address phase and rvalid read-data phase.
// The master holds req and the address/data stable until gnt arrives.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = aurora_mem_pkg::DATA_W
);

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter; tc flags the TIMEOUT_CYC-th enabled cycle.
// TIMEOUT_CYC=0 ties tc low and removes the counter.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_ctr;
      assign unused_ctr = ^{clk_i, rst_i, clr, en};
      assign tc = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt <= '0;
        end else if (clr) begin
          cnt <= '0;
        end else if (en) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Fires while the current waiting cycle is the last one allowed.
      assign tc = en & (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives the data-memory bus, stalls upstream until each
// access completes, and registers results into MEM/WB (1 cycle for non-memory ops).
module mem_stage_ctrl #(
  parameter int DATA_W      = aurora_mem_pkg::DATA_W,
  parameter int REG_ADDR_W  = aurora_mem_pkg::REG_ADDR_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_write_en_i,
  input  logic                  mem_write_en_i,
  input  logic                  mem_to_reg_i,
  input  logic [DATA_W-1:0]     alu_i,
  input  logic [DATA_W-1:0]     reg_data2_i,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
  mem_stage_ctrl_if.master      dmem,
  output logic                  stall_o,
  output logic                  reg_write_en_o,
  output logic [REG_ADDR_W-1:0] reg_write_addr_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  err_o
);

  import aurora_mem_pkg::*;

  mem_state_e state, state_nxt;
  logic is_store, is_load, is_mem;
  logic req_c, stall_c, wb_mem, abort, tmo;
  logic ctr_clr, ctr_en;

  // A store wins when both store and load flags are set.
  assign is_store = mem_write_en_i;
  assign is_load  = mem_to_reg_i & ~mem_write_en_i;
  assign is_mem   = is_store | is_load;

  assign dmem.we    = mem_write_en_i;
  assign dmem.addr  = alu_i;
  assign dmem.wdata = reg_data2_i;

  // Gated by reset so an abandoned access drops req without waiting for an edge.
  assign dmem.req = req_c & ~rst_i;
  assign stall_o  = stall_c & ~rst_i;

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    wb_mem    = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_mem) begin
          req_c = 1'b1;
          if (!dmem.gnt) begin
            stall_c   = 1'b1;
            state_nxt = REQ;
          end else if (is_load) begin
            stall_c   = 1'b1;
            state_nxt = WAIT_R;
          end
        end
      end
      REQ: begin
        if (dmem.gnt && is_store) begin
          req_c     = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          if (dmem.gnt) state_nxt = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem.rvalid) begin
          wb_mem    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ctr_en  = (state != IDLE);
  assign ctr_clr = (state_nxt == IDLE);

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .tc    (tmo)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      reg_write_en_o   <= 1'b0;
      reg_write_addr_o <= '0;
      wb_data_o        <= '0;
      err_o            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) err_o <= 1'b1;
      // Stalled or aborted cycles inject a bubble; address and data hold.
      if (stall_c || abort) begin
        reg_write_en_o <= 1'b0;
      end else begin
        reg_write_en_o   <= reg_write_en_i;
        reg_write_addr_o <= reg_write_addr_i;
        wb_data_o        <= wb_mem ? dmem.rdata : alu_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT_CYC=4): inputs change 1ns after
// the rising edge, combinational outputs are sampled on the falling edge.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_write_en_i, mem_write_en_i, mem_to_reg_i;
  logic [15:0] alu_i, reg_data2_i;
  logic [3:0]  reg_write_addr_i;
  logic        stall_o, reg_write_en_o, err_o;
  logic [3:0]  reg_write_addr_o;
  logic [15:0] wb_data_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int wb_seen  = 0;

  mem_stage_ctrl_if #(.DATA_W(16)) dmem ();

  mem_stage_ctrl #(
    .DATA_W(16), .REG_ADDR_W(4), .TIMEOUT_CYC(4)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .reg_write_en_i   (reg_write_en_i),
    .mem_write_en_i   (mem_write_en_i),
    .mem_to_reg_i     (mem_to_reg_i),
    .alu_i            (alu_i),
    .reg_data2_i      (reg_data2_i),
    .reg_write_addr_i (reg_write_addr_i),
    .dmem             (dmem),
    .stall_o          (stall_o),
    .reg_write_en_o   (reg_write_en_o),
    .reg_write_addr_o (reg_write_addr_o),
    .wb_data_o        (wb_data_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_en_i   = 1'b0;
    mem_write_en_i   = 1'b0;
    mem_to_reg_i     = 1'b0;
    alu_i            = 16'h0000;
    reg_data2_i      = 16'h0000;
    reg_write_addr_i = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem.req); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else pass_cnt++;
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL reset_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'h0) $display("FAIL reset_rwa: got %h want 0", reg_write_addr_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h0000) $display("FAIL reset_wb: got %h want 0000", wb_data_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    reg_write_en_i = 1'b1; reg_write_addr_i = 4'h3; alu_i = 16'h1234;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL nonmem_req: got %b want 0", dmem.req); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL nonmem_stall: got %b want 0", stall_o); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b1) $display("FAIL nonmem_rwe: got %b want 1", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'h3) $display("FAIL nonmem_rwa: got %h want 3", reg_write_addr_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h1234) $display("FAIL nonmem_wb: got %h want 1234", wb_data_o); else pass_cnt++;
    idle_inputs();
    alu_i = 16'h1234;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL nonmem_rwe_off: got %b want 0", reg_write_en_o); else pass_cnt++;
  endtask

  task automatic test_store();
    mem_write_en_i = 1'b1; alu_i = 16'h0040; reg_data2_i = 16'hBEEF; reg_write_addr_i = 4'h7;
    for (int i = 0; i < 4; i++) begin
      dmem.gnt = (i == 3);
      @(negedge clk);
      chk_cnt++; if (dmem.req !== 1'b1) $display("FAIL store_req[%0d]: got %b want 1", i, dmem.req); else pass_cnt++;
      chk_cnt++; if (dmem.we !== 1'b1) $display("FAIL store_we[%0d]: got %b want 1", i, dmem.we); else pass_cnt++;
      chk_cnt++; if (dmem.addr !== 16'h0040) $display("FAIL store_addr[%0d]: got %h want 0040", i, dmem.addr); else pass_cnt++;
      chk_cnt++; if (dmem.wdata !== 16'hBEEF) $display("FAIL store_wdata[%0d]: got %h want beef", i, dmem.wdata); else pass_cnt++;
      chk_cnt++; if (stall_o !== (i < 3)) $display("FAIL store_stall[%0d]: got %b want %b", i, stall_o, (i < 3)); else pass_cnt++;
      next_cycle();
      chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL store_rwe[%0d]: got %b want 0", i, reg_write_en_o); else pass_cnt++;
      if (i < 3) begin
        chk_cnt++; if (wb_data_o !== 16'h1234) $display("FAIL store_wb_hold[%0d]: got %h want 1234", i, wb_data_o); else pass_cnt++;
      end
    end
    chk_cnt++; if (wb_data_o !== 16'h0040) $display("FAIL store_wb_done: got %h want 0040", wb_data_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'h7) $display("FAIL store_rwa_done: got %h want 7", reg_write_addr_o); else pass_cnt++;
    dmem.gnt = 1'b0;
    idle_inputs();
    alu_i = 16'h0040; reg_write_addr_i = 4'h7;
  endtask

  task automatic test_load();
    mem_to_reg_i = 1'b1; reg_write_en_i = 1'b1; reg_write_addr_i = 4'h5; alu_i = 16'h0010;
    dmem.gnt = 1'b1;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b1) $display("FAIL load_req0: got %b want 1", dmem.req); else pass_cnt++;
    chk_cnt++; if (dmem.we !== 1'b0) $display("FAIL load_we0: got %b want 0", dmem.we); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b1) $display("FAIL load_stall0: got %b want 1", stall_o); else pass_cnt++;
    next_cycle();
    dmem.gnt = 1'b0;
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL load_bubble0: got %b want 0", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h0040) $display("FAIL load_wb_hold: got %h want 0040", wb_data_o); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL load_req1: got %b want 0", dmem.req); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b1) $display("FAIL load_stall1: got %b want 1", stall_o); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL load_bubble1: got %b want 0", reg_write_en_o); else pass_cnt++;
    dmem.rvalid = 1'b1; dmem.rdata = 16'hCAFE;
    @(negedge clk);
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL load_stall2: got %b want 0", stall_o); else pass_cnt++;
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL load_req2: got %b want 0", dmem.req); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b1) $display("FAIL load_rwe: got %b want 1", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'h5) $display("FAIL load_rwa: got %h want 5", reg_write_addr_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'hCAFE) $display("FAIL load_wb: got %h want cafe", wb_data_o); else pass_cnt++;
    dmem.rvalid = 1'b0; dmem.rdata = 16'h0000;
    idle_inputs();
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL load_single_wb: got %b want 0", reg_write_en_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wb_seen = 0;
    dmem.gnt = 1'b1;
    mem_to_reg_i = 1'b1; reg_write_en_i = 1'b1; reg_write_addr_i = 4'h9; alu_i = 16'h0100;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b1 || stall_o !== 1'b1) $display("FAIL b2b_c0: got req=%b stall=%b want req=1 stall=1", dmem.req, stall_o); else pass_cnt++;
    next_cycle();
    if (reg_write_en_o === 1'b1) wb_seen++;
    dmem.rvalid = 1'b1; dmem.rdata = 16'h1357;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) $display("FAIL b2b_c1: got req=%b stall=%b want req=0 stall=0", dmem.req, stall_o); else pass_cnt++;
    next_cycle();
    if (reg_write_en_o === 1'b1) wb_seen++;
    chk_cnt++; if (reg_write_addr_o !== 4'h9) $display("FAIL b2b_rwa: got %h want 9", reg_write_addr_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h1357) $display("FAIL b2b_wb: got %h want 1357", wb_data_o); else pass_cnt++;
    dmem.rvalid = 1'b0;
    mem_to_reg_i = 1'b0; mem_write_en_i = 1'b1; reg_write_en_i = 1'b0;
    reg_write_addr_i = 4'h2; alu_i = 16'h0200; reg_data2_i = 16'h2468;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || stall_o !== 1'b0) $display("FAIL b2b_c2: got req=%b we=%b stall=%b want 1 1 0", dmem.req, dmem.we, stall_o); else pass_cnt++;
    next_cycle();
    if (reg_write_en_o === 1'b1) wb_seen++;
    chk_cnt++; if (wb_data_o !== 16'h0200) $display("FAIL b2b_store_wb: got %h want 0200", wb_data_o); else pass_cnt++;
    dmem.gnt = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL b2b_c3_req: got %b want 0", dmem.req); else pass_cnt++;
    next_cycle();
    if (reg_write_en_o === 1'b1) wb_seen++;
    chk_cnt++; if (wb_seen !== 1) $display("FAIL b2b_wb_count: got %0d want 1", wb_seen); else pass_cnt++;
  endtask

  task automatic test_timeout();
    reg_write_en_i = 1'b1; reg_write_addr_i = 4'hA; alu_i = 16'h5A5A;
    next_cycle();
    mem_to_reg_i = 1'b1; reg_write_addr_i = 4'hB; alu_i = 16'h0300;
    dmem.gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++; if (dmem.req !== (i < 4)) $display("FAIL tmo_req[%0d]: got %b want %b", i, dmem.req, (i < 4)); else pass_cnt++;
      chk_cnt++; if (stall_o !== (i < 4)) $display("FAIL tmo_stall[%0d]: got %b want %b", i, stall_o, (i < 4)); else pass_cnt++;
      chk_cnt++; if (err_o !== 1'b0) $display("FAIL tmo_err_early[%0d]: got %b want 0", i, err_o); else pass_cnt++;
      next_cycle();
      chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL tmo_bubble[%0d]: got %b want 0", i, reg_write_en_o); else pass_cnt++;
      chk_cnt++; if (wb_data_o !== 16'h5A5A) $display("FAIL tmo_wb_hold[%0d]: got %h want 5a5a", i, wb_data_o); else pass_cnt++;
    end
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL tmo_err_set: got %b want 1", err_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'hA) $display("FAIL tmo_rwa_hold: got %h want a", reg_write_addr_o); else pass_cnt++;
    idle_inputs();
    dmem.gnt = 1'b1; dmem.rvalid = 1'b1; dmem.rdata = 16'hFFFF;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) $display("FAIL tmo_stray: got req=%b stall=%b want 0 0", dmem.req, stall_o); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL tmo_stray_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h0000) $display("FAIL tmo_stray_wb: got %h want 0000", wb_data_o); else pass_cnt++;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 16'h0000;
    next_cycle();
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", err_o); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    reg_write_en_i = 1'b1; reg_write_addr_i = 4'hF; alu_i = 16'h7777;
    next_cycle();
    mem_to_reg_i = 1'b1; reg_write_addr_i = 4'h6; alu_i = 16'h0400;
    dmem.gnt = 1'b1;
    @(negedge clk);
    chk_cnt++; if (stall_o !== 1'b1) $display("FAIL arst_pre_stall: got %b want 1", stall_o); else pass_cnt++;
    next_cycle();
    dmem.gnt = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_cnt++; if (dmem.req !== 1'b0) $display("FAIL arst_req: got %b want 0", dmem.req); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL arst_stall: got %b want 0", stall_o); else pass_cnt++;
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL arst_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (reg_write_addr_o !== 4'h0) $display("FAIL arst_rwa: got %h want 0", reg_write_addr_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h0000) $display("FAIL arst_wb: got %h want 0000", wb_data_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL arst_err: got %b want 0", err_o); else pass_cnt++;
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    dmem.rvalid = 1'b1; dmem.rdata = 16'hDEAD;
    @(negedge clk);
    chk_cnt++; if (dmem.req !== 1'b0 || stall_o !== 1'b0) $display("FAIL arst_late_comb: got req=%b stall=%b want 0 0", dmem.req, stall_o); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (reg_write_en_o !== 1'b0) $display("FAIL arst_late_rwe: got %b want 0", reg_write_en_o); else pass_cnt++;
    chk_cnt++; if (wb_data_o !== 16'h0000) $display("FAIL arst_late_wb: got %h want 0000", wb_data_o); else pass_cnt++;
    dmem.rvalid = 1'b0; dmem.rdata = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
